router_port_rx: RTL and testbench

//  Receiver for one serial router input port (din/frame_n/valid_n). Parses each frame

---
 rtl/router_port_rx.sv | 195 +++++++++++++++++++
 tb/tb_router_port_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_port_rx.sv
// router_port_rx: serial router input-port receiver (addr, pad, LSB-first bytes).
// Optional macro ROUTER_RX_PAD_CHECK_EN: valid_n=0 during pad aborts the frame.
//
// Ports:
//   clock, reset_n            clock / async active-low reset
//   din, frame_n, valid_n     serial port inputs, sampled on posedge clock
//   pkt_addr, addr_valid      captured destination address + 1-cycle pulse
//   dout_byte, byte_valid     assembled byte + 1-cycle pulse
//   sop, eop                  first/last byte of frame (qualified by byte_valid)
//   err                       1-cycle pulse: malformed frame dropped
//   busy                      receiver is inside a frame
module router_port_rx #(
    parameter int ADDR_W     = 4,
    parameter int PAD_CYCLES = 5,
    parameter int DATA_W     = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              din,
    input  logic              frame_n,
    input  logic              valid_n,
    output logic [ADDR_W-1:0] pkt_addr,
    output logic              addr_valid,
    output logic [DATA_W-1:0] dout_byte,
    output logic              byte_valid,
    output logic              sop,
    output logic              eop,
    output logic              err,
    output logic              busy
);

    localparam int AC_W = $clog2(ADDR_W + 1);
    localparam int PC_W = $clog2(PAD_CYCLES + 1);
    localparam int BC_W = $clog2(DATA_W + 1);

    localparam logic [AC_W-1:0] A_LAST = AC_W'(ADDR_W - 1);
    localparam logic [PC_W-1:0] P_LAST = PC_W'(PAD_CYCLES - 1);
    localparam logic [BC_W-1:0] B_LAST = BC_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        PAD,
        DATA
    } state_t;

    state_t state_q, state_d;

    logic [AC_W-1:0]   acnt_q, acnt_d;
    logic [PC_W-1:0]   pcnt_q, pcnt_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    // Partial words hold all but the final bit; the final bit comes
    // straight from din on the completing cycle.
    logic [ADDR_W-2:0] areg_q, areg_d;
    logic [DATA_W-2:0] sreg_q, sreg_d;
    logic              first_q, first_d;

    logic [ADDR_W-1:0] pkt_addr_d;
    logic [DATA_W-1:0] dout_d;
    logic              addr_valid_d;
    logic              byte_valid_d;
    logic              sop_d;
    logic              eop_d;
    logic              err_d;
    logic              pad_err;

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        acnt_d       = acnt_q;
        pcnt_d       = pcnt_q;
        bcnt_d       = bcnt_q;
        areg_d       = areg_q;
        sreg_d       = sreg_q;
        first_d      = first_q;
        pkt_addr_d   = pkt_addr;
        dout_d       = dout_byte;
        addr_valid_d = 1'b0;
        byte_valid_d = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        err_d        = 1'b0;
`ifdef ROUTER_RX_PAD_CHECK_EN
        pad_err      = !valid_n;
`else
        pad_err      = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (!frame_n) begin
                    areg_d  = {din, areg_q[ADDR_W-2:1]};
                    acnt_d  = AC_W'(1);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (frame_n) begin
                    err_d   = 1'b1;
                    acnt_d  = '0;
                    state_d = IDLE;
                end else if (acnt_q == A_LAST) begin
                    pkt_addr_d   = {din, areg_q};
                    addr_valid_d = 1'b1;
                    acnt_d       = '0;
                    pcnt_d       = '0;
                    state_d      = PAD;
                end else begin
                    areg_d = {din, areg_q[ADDR_W-2:1]};
                    acnt_d = acnt_q + AC_W'(1);
                end
            end
            PAD: begin
                if (frame_n || pad_err) begin
                    err_d   = 1'b1;
                    pcnt_d  = '0;
                    state_d = IDLE;
                end else if (pcnt_q == P_LAST) begin
                    pcnt_d  = '0;
                    bcnt_d  = '0;
                    first_d = 1'b1;
                    state_d = DATA;
                end else begin
                    pcnt_d = pcnt_q + PC_W'(1);
                end
            end
            DATA: begin
                if (!valid_n) begin
                    if (bcnt_q == B_LAST) begin
                        dout_d       = {din, sreg_q};
                        byte_valid_d = 1'b1;
                        sop_d        = first_q;
                        eop_d        = frame_n;
                        first_d      = 1'b0;
                        bcnt_d       = '0;
                        if (frame_n) begin
                            state_d = IDLE;
                        end
                    end else if (frame_n) begin
                        // Frame ended mid-byte: drop partial data.
                        err_d   = 1'b1;
                        bcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        sreg_d = {din, sreg_q[DATA_W-2:1]};
                        bcnt_d = bcnt_q + BC_W'(1);
                    end
                end else if (frame_n) begin
                    err_d   = 1'b1;
                    bcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            acnt_q     <= '0;
            pcnt_q     <= '0;
            bcnt_q     <= '0;
            areg_q     <= '0;
            sreg_q     <= '0;
            first_q    <= 1'b0;
            pkt_addr   <= '0;
            dout_byte  <= '0;
            addr_valid <= 1'b0;
            byte_valid <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            acnt_q     <= acnt_d;
            pcnt_q     <= pcnt_d;
            bcnt_q     <= bcnt_d;
            areg_q     <= areg_d;
            sreg_q     <= sreg_d;
            first_q    <= first_d;
            pkt_addr   <= pkt_addr_d;
            dout_byte  <= dout_d;
            addr_valid <= addr_valid_d;
            byte_valid <= byte_valid_d;
            sop        <= sop_d;
            eop        <= eop_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_router_port_rx.sv
// tb_router_port_rx: scoreboard bench for router_port_rx.
// Expected output events (with their cycle) are queued by the driver.
module tb_router_port_rx;

    logic       clock;
    logic       reset_n;
    logic       din;
    logic       frame_n;
    logic       valid_n;
    logic [3:0] pkt_addr;
    logic       addr_valid;
    logic [7:0] dout_byte;
    logic       byte_valid;
    logic       sop;
    logic       eop;
    logic       err;
    logic       busy;

    router_port_rx dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .din        (din),
        .frame_n    (frame_n),
        .valid_n    (valid_n),
        .pkt_addr   (pkt_addr),
        .addr_valid (addr_valid),
        .dout_byte  (dout_byte),
        .byte_valid (byte_valid),
        .sop        (sop),
        .eop        (eop),
        .err        (err),
        .busy       (busy)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic        av;
        logic        bv;
        logic        so;
        logic        eo;
        logic        er;
        logic [3:0]  a;
        logic [7:0]  d;
    } ev_t;

    ev_t exp_q[$];
    int  cyc;
    int  n_cmp;
    int  n_bad;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    task automatic push_ev(input logic av, input logic bv,
                           input logic so, input logic eo,
                           input logic er, input logic [3:0] a,
                           input logic [7:0] d);
        ev_t e;
        e.cyc = 32'(cyc + 1);
        e.av  = av;
        e.bv  = bv;
        e.so  = so;
        e.eo  = eo;
        e.er  = er;
        e.a   = a;
        e.d   = d;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops one expected event per output pulse.
    initial begin
        ev_t o;
        ev_t e;
        forever begin
            @(negedge clock);
            if (reset_n && (addr_valid || byte_valid || err)) begin
                o.cyc = 32'(cyc);
                o.av  = addr_valid;
                o.bv  = byte_valid;
                o.so  = sop;
                o.eo  = eop;
                o.er  = err;
                o.a   = addr_valid ? pkt_addr : 4'h0;
                o.d   = byte_valid ? dout_byte : 8'h00;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got %h expected none", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        n_bad++;
                        $display("FAIL event: got cyc=%0d av=%b bv=%b sop=%b eop=%b err=%b a=%h d=%h expected cyc=%0d av=%b bv=%b sop=%b eop=%b err=%b a=%h d=%h",
                                 o.cyc, o.av, o.bv, o.so, o.eo, o.er, o.a, o.d,
                                 e.cyc, e.av, e.bv, e.so, e.eo, e.er, e.a, e.d);
                    end
                end
            end
        end
    end

    task automatic drive(input logic f, input logic v, input logic d);
        @(negedge clock);
        frame_n = f;
        valid_n = v;
        din     = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b0);
    endtask

    task automatic send_addr(input logic [3:0] a);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, a[i]);
            if (i == 3) push_ev(1, 0, 0, 0, 0, a, 8'h00);
        end
    endtask

    task automatic send_pad();
        repeat (5) drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic first,
                             input logic last, input int bub_at,
                             input int nbub);
        for (int i = 0; i < 8; i++) begin
            if (i == bub_at) repeat (nbub) drive(1'b0, 1'b1, 1'b1);
            drive((last && i == 7) ? 1'b1 : 1'b0, 1'b0, b[i]);
            if (i == 7) push_ev(0, 1, first, last, 0, 4'h0, b);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        cyc     = 0;
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        frame_n = 1'b1;
        valid_n = 1'b1;
        din     = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("reset_outputs",
              32'({pkt_addr, addr_valid, dout_byte, byte_valid,
                   sop, eop, err, busy}), 32'h0);

        // Basic two-byte frame.
        send_addr(4'h3);
        check("busy_in_frame", 32'(busy), 32'h1);
        send_pad();
        send_byte(8'h33, 1, 0, -1, 0);
        send_byte(8'h77, 0, 1, -1, 0);
        idle(2);
        check("pkt_addr_3", 32'(pkt_addr), 32'h3);
        check("busy_after_frame", 32'(busy), 32'h0);

        // Same frame with bubbles mid-byte.
        send_addr(4'h3);
        send_pad();
        send_byte(8'h33, 1, 0, 3, 2);
        send_byte(8'h77, 0, 1, 6, 1);
        idle(2);

        // Frame ends after 5 data bits.
        send_addr(4'h5);
        send_pad();
        b = 8'h1F;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, b[i]);
        drive(1'b1, 1'b1, 1'b0);
        push_ev(0, 0, 0, 0, 1, 4'h0, 8'h00);
        @(negedge clock);
        check("busy_after_err", 32'(busy), 32'h0);
        idle(1);

        // Last bit arriving mid-byte (frame_n=1, valid_n=0).
        send_addr(4'h7);
        send_pad();
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        push_ev(0, 0, 0, 0, 1, 4'h0, 8'h00);
        idle(2);

        // Abort during address.
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        push_ev(0, 0, 0, 0, 1, 4'h0, 8'h00);
        idle(2);

        // Abort during pad.
        send_addr(4'h9);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        push_ev(0, 0, 0, 0, 1, 4'h0, 8'h00);
        idle(2);

        // Reset during the second byte.
        send_addr(4'h6);
        send_pad();
        send_byte(8'h12, 1, 0, -1, 0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_mid_busy", 32'(busy), 32'h0);
        check("reset_mid_addr", 32'(pkt_addr), 32'h0);
        check("reset_mid_byte", 32'(dout_byte), 32'h0);
        frame_n = 1'b1;
        valid_n = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        idle(1);
        send_addr(4'hA);
        send_pad();
        send_byte(8'h5C, 1, 1, -1, 0);
        idle(2);

        // Back-to-back frames.
        send_addr(4'h1);
        send_pad();
        send_byte(8'h01, 1, 1, -1, 0);
        send_addr(4'h2);
        send_pad();
        send_byte(8'hF0, 1, 1, -1, 0);
        idle(2);
        check("pkt_addr_b2b", 32'(pkt_addr), 32'h2);

        // valid_n low in pad cycle 3.
        send_addr(4'hC);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
`ifdef ROUTER_RX_PAD_CHECK_EN
        push_ev(0, 0, 0, 0, 1, 4'h0, 8'h00);
        idle(2);
`else
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        send_byte(8'hA5, 1, 1, -1, 0);
        idle(2);
`endif

        idle(4);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
